// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register-file write port arbiter: ALU bypass with priority over a 4-deep MDU result FIFO
// Enforces WAW ordering by killing buffered MDU results that an issued ALU write has superseded.
module writeback_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        regWrite,
  input  logic [4:0]  query_reg,
  output logic        pending_hit,
  output logic [2:0]  pending_count
);

  logic [4:0]  r_fifo_reg  [4];
  logic [31:0] r_fifo_data [4];
  logic [3:0]  r_fifo_kill;
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_count;
  logic        r_regwrite;
  logic [4:0]  r_write_reg;
  logic [31:0] r_write_data;

  logic       w_full;
  logic       w_empty;
  logic       w_alu_issue;
  logic       w_push;
  logic       w_pop;
  logic       w_head_live;
  logic [3:0] w_valid;
  logic [3:0] w_match;
  logic [1:0] w_off;
  logic       w_fifo_hit;
  logic       w_out_hit;

  assign w_full      = (r_count == 3'd4);
  assign w_empty     = (r_count == 3'd0);
  assign mdu_ready   = !w_full && !reset;
  assign w_alu_issue = alu_valid && (alu_reg != 5'd0);
  assign w_push      = mdu_valid && mdu_ready && (mdu_reg != 5'd0);
  assign w_pop       = !w_alu_issue && !w_empty;
  assign w_head_live = !r_fifo_kill[r_rptr];

  // An entry is occupied when its distance from the read pointer is below the count.
  always_comb begin
    w_valid = 4'd0;
    w_match = 4'd0;
    w_off   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_off      = 2'(i) - r_rptr;
      w_valid[i] = ({1'b0, w_off} < r_count);
      w_match[i] = (r_fifo_reg[i] == query_reg);
    end
  end

  assign w_fifo_hit    = |(w_valid & ~r_fifo_kill & w_match);
  assign w_out_hit     = r_regwrite && (r_write_reg == query_reg);
  assign pending_hit   = (query_reg != 5'd0) && (w_fifo_hit || w_out_hit);
  assign pending_count = r_count;
  assign regWrite      = r_regwrite;
  assign write_reg     = r_write_reg;
  assign write_data    = r_write_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_fifo_reg[i]  <= 5'd0;
        r_fifo_data[i] <= 32'd0;
      end
      r_fifo_kill  <= 4'd0;
      r_wptr       <= 2'd0;
      r_rptr       <= 2'd0;
      r_count      <= 3'd0;
      r_regwrite   <= 1'b0;
      r_write_reg  <= 5'd0;
      r_write_data <= 32'd0;
    end else begin
      // Free slots may also be marked; a push always rewrites its own kill flag.
      if (w_alu_issue) begin
        for (int i = 0; i < 4; i++) begin
          if (r_fifo_reg[i] == alu_reg) begin
            r_fifo_kill[i] <= 1'b1;
          end
        end
      end
      if (w_push) begin
        r_fifo_reg[r_wptr]  <= mdu_reg;
        r_fifo_data[r_wptr] <= mdu_data;
        r_fifo_kill[r_wptr] <= w_alu_issue && (mdu_reg == alu_reg);
        r_wptr              <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_alu_issue) begin
        r_regwrite   <= 1'b1;
        r_write_reg  <= alu_reg;
        r_write_data <= alu_data;
      end else if (w_pop && w_head_live) begin
        r_regwrite   <= 1'b1;
        r_write_reg  <= r_fifo_reg[r_rptr];
        r_write_data <= r_fifo_data[r_rptr];
      end else begin
        r_regwrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - randomized and directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        regWrite;
  logic [4:0]  query_reg;
  logic        pending_hit;
  logic [2:0]  pending_count;

  writeback_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_reg(mdu_reg), .mdu_data(mdu_data),
    .write_reg(write_reg), .write_data(write_data), .regWrite(regWrite),
    .query_reg(query_reg), .pending_hit(pending_hit), .pending_count(pending_count)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    logic        k;
  } ent_t;

  ent_t        q[$];
  logic        m_wr;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          n_checks;
  int          n_errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_wr   = 1'b0;
    m_reg  = 5'd0;
    m_data = 32'd0;
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle, advance model and check the write port.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mr, input logic [31:0] md,
                      input logic [4:0] qr);
    logic exp_ready;
    logic exp_hit;
    logic alu_iss;
    logic popped;
    ent_t e;
    ent_t n;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mdu_valid = mv; mdu_reg = mr; mdu_data = md;
    query_reg = qr;
    @(negedge clk);
    exp_ready = (q.size() < 4);
    exp_hit   = 1'b0;
    if (qr != 5'd0) begin
      foreach (q[i]) if (!q[i].k && q[i].r == qr) exp_hit = 1'b1;
      if (m_wr && m_reg == qr) exp_hit = 1'b1;
    end
    check_eq("mdu_ready", mdu_ready, exp_ready);
    check_eq("pending_hit", pending_hit, exp_hit);
    check_eq("pending_count", pending_count, q.size());

    alu_iss = av && (ar != 5'd0);
    popped  = 1'b0;
    e.r = 5'd0; e.d = 32'd0; e.k = 1'b0;
    if (!alu_iss && q.size() > 0) begin
      e = q.pop_front();
      popped = 1'b1;
    end
    if (alu_iss) foreach (q[i]) if (q[i].r == ar) q[i].k = 1'b1;
    if (mv && exp_ready && mr != 5'd0) begin
      n.r = mr; n.d = md; n.k = alu_iss && (mr == ar);
      q.push_back(n);
    end
    if (alu_iss) begin
      m_wr = 1'b1; m_reg = ar; m_data = ad;
    end else if (popped && !e.k) begin
      m_wr = 1'b1; m_reg = e.r; m_data = e.d;
    end else begin
      m_wr = 1'b0;
    end

    @(posedge clk);
    #1;
    check_eq("regWrite", regWrite, m_wr);
    check_eq("write_reg", write_reg, m_reg);
    check_eq("write_data", write_data, m_data);
  endtask

  task automatic idle(input logic [4:0] qr);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qr);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_clear();
    reset = 1'b1;
    alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'd0;
    mdu_valid = 1'b0; mdu_reg = 5'd0; mdu_data = 32'd0;
    query_reg = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_regWrite", regWrite, 1'b0);
    check_eq("reset_write_reg", write_reg, 5'd0);
    check_eq("reset_write_data", write_data, 32'd0);
    check_eq("reset_count", pending_count, 3'd0);
    check_eq("reset_mdu_ready", mdu_ready, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("post_reset_mdu_ready", mdu_ready, 1'b1);

    // ALU bypass
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5);
    check_eq("bypass_data", write_data, 32'hDEADBEEF);
    idle(5'd5);
    check_eq("bypass_idle_wr", regWrite, 1'b0);

    // FIFO full while the ALU holds the port, then drain in order
    for (int i = 0; i < 5; i++)
      step(1'b1, 5'(10 + i), 32'h100 + i, 1'b1, 5'(1 + (i % 4)), 32'hA0 + i, 5'd2);
    check_eq("full_count", pending_count, 3'd4);
    check_eq("full_ready", mdu_ready, 1'b0);
    for (int i = 0; i < 6; i++) idle(5'd3);

    // WAW kill
    step(1'b1, 5'd9, 32'h9, 1'b1, 5'd7, 32'h11, 5'd7);
    step(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0, 5'd7);
    check_eq("waw_alu_data", write_data, 32'h22);
    idle(5'd7);
    check_eq("waw_killed_pop", regWrite, 1'b0);
    idle(5'd7);
    check_eq("waw_no_hit", pending_hit, 1'b0);

    // Zero register on both sources
    step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 5'd0);
    check_eq("zero_regWrite", regWrite, 1'b0);
    check_eq("zero_count", pending_count, 3'd0);
    check_eq("zero_ready", mdu_ready, 1'b1);

    // Reset pulsed between edges with 3 entries pending
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'(20 + i), 32'h200 + i, 1'b1, 5'(24 + i), 32'h300 + i, 5'd0);
    #1 reset = 1'b1;
    #1;
    check_eq("midrst_regWrite", regWrite, 1'b0);
    check_eq("midrst_write_reg", write_reg, 5'd0);
    check_eq("midrst_write_data", write_data, 32'd0);
    check_eq("midrst_count", pending_count, 3'd0);
    check_eq("midrst_ready", mdu_ready, 1'b0);
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) idle(5'(24 + (i % 3)));

    // Wrap-around: 10 back-to-back MDU results, ALU idle
    for (int i = 0; i < 10; i++)
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'(1 + i), 32'hC00 + i, 5'(i));
    idle(5'd10);
    idle(5'd10);

    // Randomized traffic over a small register range to provoke hazards and kills
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)));
    for (int i = 0; i < 6; i++) idle(5'($urandom_range(0, 7)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
